// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle RV32I core: steps one instruction through
// fetch, decode, execute, memory and write-back, with memory timeout and illegal-opcode traps.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  aluop,
    output logic        busy,
    output logic        retire,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] instr_count
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_EXEC_R,
        S_WB_R,
        S_BRANCH,
        S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   instr_count_q, instr_count_d;
    logic [1:0]    fault_code_q, fault_code_d;

    logic in_mem_state;
    logic timeout;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        instr_count_d = instr_count_q;
        wait_cnt_d    = '0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        retire        = 1'b0;

        in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        timeout      = in_mem_state && !mem_ready && (MEM_TIMEOUT != 0)
                       && (wait_cnt_q == CW'(MEM_TIMEOUT - 1));

        // Leaving a memory state (or any ready cycle) zeroes the counter, which covers "clear on entry".
        if (in_mem_state && !mem_ready && (MEM_TIMEOUT != 0) && !timeout) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                if (opcode == OP_R) begin
                    state_d = S_EXEC_R;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_BRANCH) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d      = S_FAULT;
                    fault_code_d = FC_ILLEGAL;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = 2'b01;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // run is only looked at here and in IDLE, so dropping it never aborts an instruction.
        if (retire) begin
            instr_count_d = instr_count_q + 32'd1;
            state_d       = run ? S_FETCH : S_IDLE;
        end

        if (timeout) begin
            state_d      = S_FAULT;
            fault_code_d = FC_TIMEOUT;
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign fault       = (state_q == S_FAULT);
    assign fault_code  = fault_code_q;
    assign instr_count = instr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
            fault_code_q  <= 2'b00;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
            fault_code_q  <= fault_code_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: per-instruction expectations come
// from latency and control-count rules, a monitor compares them at every retire or fault.
module tb_multicycle_control_fsm;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n, run, zero, mem_ready;
    logic [6:0]  opcode;
    logic        pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write, mem_to_reg;
    logic        alu_src_a, busy, retire, fault;
    logic [1:0]  alu_src_b, aluop, fault_code;
    logic [31:0] instr_count;

    multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
        .busy(busy), .retire(retire), .fault(fault), .fault_code(fault_code),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [12:0] ctl;
    logic [17:0] all_out;
    assign ctl     = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                      mem_to_reg, alu_src_a, alu_src_b, aluop};
    assign all_out = {ctl, busy, retire, fault, fault_code};

    typedef enum {K_R, K_LW, K_SW, K_BEQ, K_ILL, K_TMO} kind_e;

    typedef struct {
        kind_e       kind;
        int          cycles;
        int          reads;
        int          writes;
        int          iord;
        int          fetch;
        int          irw;
        int          imm;
        int          srca;
        int          regw;
        int          aluf;
        logic        taken;
        logic [31:0] count;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_count;
    logic [6:0]  ill_op;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Monitor: accumulates per-instruction activity and compares at each retire or fault entry.
    int   m_cyc, m_rd, m_wr, m_iord, m_fetch, m_irw, m_imm, m_srca, m_rw, m_af;
    logic fault_seen;
    exp_t e_mon;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_cyc = 0; m_rd = 0; m_wr = 0; m_iord = 0; m_fetch = 0;
                m_irw = 0; m_imm = 0; m_srca = 0; m_rw = 0; m_af = 0;
                fault_seen = 1'b0;
            end else begin
                if (busy) begin
                    m_cyc++;
                    if (mem_read) m_rd++;
                    if (mem_write) m_wr++;
                    if (iord) m_iord++;
                    if (mem_read && !iord && alu_src_b == 2'b01 && !alu_src_a) m_fetch++;
                    if (ir_write) m_irw++;
                    if (alu_src_b == 2'b10 && aluop == 2'b00) m_imm++;
                    if (alu_src_a) m_srca++;
                    if (reg_write) m_rw++;
                    if (aluop == 2'b10) m_af++;
                end
                if (retire || (fault && !fault_seen)) begin
                    if (sb.size() == 0) begin
                        check("unexpected_event", 32'd1, 32'd0);
                    end else begin
                        e_mon = sb.pop_front();
                        check($sformatf("%s_is_fault", e_mon.kind.name()), 32'(fault),
                              32'(e_mon.kind == K_ILL || e_mon.kind == K_TMO));
                        check($sformatf("%s_cycles", e_mon.kind.name()), m_cyc, e_mon.cycles);
                        check($sformatf("%s_mem_read_cycles", e_mon.kind.name()), m_rd, e_mon.reads);
                        check($sformatf("%s_mem_write_cycles", e_mon.kind.name()), m_wr, e_mon.writes);
                        check($sformatf("%s_iord_cycles", e_mon.kind.name()), m_iord, e_mon.iord);
                        check($sformatf("%s_fetch_cycles", e_mon.kind.name()), m_fetch, e_mon.fetch);
                        check($sformatf("%s_ir_write_cycles", e_mon.kind.name()), m_irw, e_mon.irw);
                        check($sformatf("%s_imm_add_cycles", e_mon.kind.name()), m_imm, e_mon.imm);
                        check($sformatf("%s_src_a_rs1_cycles", e_mon.kind.name()), m_srca, e_mon.srca);
                        check($sformatf("%s_reg_write_cycles", e_mon.kind.name()), m_rw, e_mon.regw);
                        check($sformatf("%s_funct_alu_cycles", e_mon.kind.name()), m_af, e_mon.aluf);
                        if (fault) begin
                            check("fault_code", 32'(fault_code), 32'(e_mon.code));
                            check("fault_controls_zero", {busy, ctl}, 32'd0);
                        end else begin
                            check($sformatf("%s_instr_count", e_mon.kind.name()), instr_count, e_mon.count);
                            check($sformatf("%s_retire_pc_write", e_mon.kind.name()), 32'(pc_write),
                                  32'(e_mon.kind == K_BEQ && e_mon.taken));
                            check($sformatf("%s_retire_mem_to_reg", e_mon.kind.name()), 32'(mem_to_reg),
                                  32'(e_mon.kind == K_LW));
                            if (e_mon.kind == K_BEQ)
                                check("beq_branch_ctl", {pc_src, alu_src_a, alu_src_b, aluop},
                                      {26'd0, 1'b1, 1'b1, 2'b00, 2'b01});
                        end
                    end
                    m_cyc = 0; m_rd = 0; m_wr = 0; m_iord = 0; m_fetch = 0;
                    m_irw = 0; m_imm = 0; m_srca = 0; m_rw = 0; m_af = 0;
                end
                fault_seen = fault;
            end
        end
    end

    // Issues one instruction starting in a FETCH cycle; s_m < 0 with K_TMO times out in FETCH.
    task automatic issue(input kind_e k, input int s_f, input int s_m, input logic z, input int drop_at);
        logic plan[$];
        exp_t e;
        e.kind = k; e.reads = 0; e.writes = 0; e.iord = 0; e.fetch = 0; e.irw = 1;
        e.imm = 1; e.srca = 0; e.regw = 0; e.aluf = 0; e.taken = z; e.count = model_count;
        e.code = (k == K_ILL) ? 2'b01 : (k == K_TMO) ? 2'b10 : 2'b00;
        if (k == K_TMO && s_m < 0) begin
            repeat (TMO) plan.push_back(1'b0);
            e.reads = TMO; e.fetch = TMO; e.irw = 0; e.imm = 0;
        end else begin
            repeat (s_f) plan.push_back(1'b0);
            plan.push_back(1'b1);
            plan.push_back(rnd_bit());
            e.reads = s_f + 1; e.fetch = s_f + 1;
            case (k)
                K_R: begin
                    plan.push_back(rnd_bit()); plan.push_back(rnd_bit());
                    e.regw = 1; e.aluf = 1; e.srca = 1;
                end
                K_BEQ: begin
                    plan.push_back(rnd_bit());
                    e.srca = 1;
                end
                K_SW: begin
                    plan.push_back(rnd_bit());
                    repeat (s_m) plan.push_back(1'b0);
                    plan.push_back(1'b1);
                    e.writes = s_m + 1; e.iord = s_m + 1; e.imm = 2; e.srca = 1;
                end
                K_LW: begin
                    plan.push_back(rnd_bit());
                    repeat (s_m) plan.push_back(1'b0);
                    plan.push_back(1'b1);
                    plan.push_back(rnd_bit());
                    e.reads += s_m + 1; e.iord = s_m + 1; e.regw = 1; e.imm = 2; e.srca = 1;
                end
                K_TMO: begin
                    plan.push_back(rnd_bit());
                    repeat (TMO) plan.push_back(1'b0);
                    e.reads += TMO; e.iord = TMO; e.imm = 2; e.srca = 1;
                end
                default: ;
            endcase
        end
        e.cycles = plan.size();
        case (k)
            K_R:     opcode = 7'b0110011;
            K_SW:    opcode = 7'b0100011;
            K_BEQ:   opcode = 7'b1100011;
            K_ILL:   opcode = ill_op;
            default: opcode = 7'b0000011;
        endcase
        zero = z;
        sb.push_back(e);
        foreach (plan[i]) begin
            if (i == drop_at) run = 1'b0;
            mem_ready = plan[i];
            @(posedge clk); #2;
        end
        if (k == K_R || k == K_LW || k == K_SW || k == K_BEQ) model_count++;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("async_reset_outputs", 32'(all_out), 32'd0);
        check("async_reset_count", instr_count, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_count = '0;
        @(negedge clk);
        check("idle_after_reset", 32'(all_out), 32'd0);
    endtask

    task automatic begin_fetch();
        run = 1'b1;
        @(posedge clk); #2;
    endtask

    kind_e rk;
    int    rsf, rsm, rdrop;

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
        model_count = '0; ill_op = 7'b0010011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(all_out), 32'd0);
        check("reset_count", instr_count, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'(all_out), 32'd0);

        // Directed latency and stall cases, including a ready on the 16th waiting cycle.
        begin_fetch();
        issue(K_R,   0,  0, 1'b0, -1);
        issue(K_LW,  0,  3, 1'b0, -1);
        issue(K_BEQ, 0,  0, 1'b1, -1);
        issue(K_BEQ, 0,  0, 1'b0, -1);
        issue(K_SW,  1,  2, 1'b0, -1);
        issue(K_R,   15, 0, 1'b0, -1);
        issue(K_LW,  2, 15, 1'b1, -1);
        issue(K_SW,  0, 15, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            rk    = kind_e'($urandom_range(3, 0));
            rsf   = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(3, 0));
            rsm   = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(3, 0));
            rdrop = ($urandom_range(5, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
            issue(rk, rsf, rsm, rnd_bit(), rdrop);
            if (!run) begin
                @(negedge clk);
                check("idle_after_stop", 32'(all_out), 32'd0);
                begin_fetch();
            end
        end

        // run dropped in the first MEM_WR cycle: the store still completes, then IDLE.
        issue(K_SW, 0, 2, 1'b0, 3);
        repeat (3) begin
            @(negedge clk);
            check("stop_in_mem_wr_idle", 32'(all_out), 32'd0);
        end
        check("stop_count", instr_count, model_count);

        begin_fetch();
        issue(K_ILL, 1, 0, 1'b0, -1);
        repeat (22) begin
            run = rnd_bit(); mem_ready = rnd_bit();
            @(negedge clk);
            check("illegal_fault_hold", 32'(all_out), {14'd0, 13'd0, 1'b0, 1'b0, 1'b1, 2'b01});
        end
        do_reset();

        ill_op = 7'b1101111;
        begin_fetch();
        issue(K_ILL, 0, 0, 1'b0, -1);
        do_reset();

        begin_fetch();
        issue(K_TMO, 0, -1, 1'b0, -1);
        repeat (3) begin
            @(negedge clk);
            check("fetch_timeout_hold", 32'(all_out), {14'd0, 13'd0, 1'b0, 1'b0, 1'b1, 2'b10});
        end
        do_reset();

        begin_fetch();
        issue(K_TMO, 1, 0, 1'b0, -1);
        do_reset();

        // Asynchronous reset in the middle of a load's MEM_RD wait.
        begin_fetch();
        issue(K_R, 0, 0, 1'b0, -1);
        opcode = 7'b0000011; mem_ready = 1'b1;
        @(posedge clk); #2;
        mem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
        end
        check("mid_mem_rd_ctl", {iord, mem_read, busy}, 32'd7);
        check("mid_mem_rd_count", instr_count, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_mem_rd_reset_outputs", 32'(all_out), 32'd0);
        check("mid_mem_rd_reset_count", instr_count, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_count = '0;
        begin_fetch();
        issue(K_BEQ, 0, 0, 1'b1, -1);
        run = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control sequencer for the multi-cycle RV32I core. It sequences one shared ALU, one shared instruction/data memory port and the register file over several cycles per instruction.
- Emits the 2-bit aluop consumed by the existing ALU control decoder: 00 add, 01 sub, 10 funct-decoded.
- Handles variable-latency memory through a ready handshake with a timeout, traps illegal opcodes, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready cycles in a memory state before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  permit fetching new instructions
- opcode  in  7  instr[6:0] from the IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = rs1
- alu_src_b  out  2  ALU B operand: 00 = rs2, 01 = constant 4, 10 = immediate
- aluop  out  2  to ALU control
- busy  out  1  state is neither IDLE nor FAULT
- retire  out  1  one-cycle pulse on instruction completion
- fault  out  1  in FAULT state
- fault_code  out  2  01 = illegal opcode, 10 = memory timeout
- instr_count  out  32  retired instruction count

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE; wait_cnt, instr_count and fault_code = 0. All outputs are 0 while reset is held and in IDLE.
- Outputs are a function of state, plus mem_ready/zero where noted. Any output not listed for a state is 0.
- IDLE:
  - no outputs asserted
  - run=1 -> FETCH
- FETCH:
  - outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00
  - if mem_ready=1: ir_write=1, pc_write=1, pc_src=0 -> DECODE
- DECODE:
  - outputs: alu_src_a=0, alu_src_b=10, aluop=00 (computes the branch target)
  - opcode 0110011 -> EXEC_R
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - any other opcode -> FAULT, fault_code=01
- MEM_ADDR:
  - outputs: alu_src_a=1, alu_src_b=10, aluop=00
  - load -> MEM_RD; store -> MEM_WR (opcode is held stable from the IR)
- MEM_RD:
  - outputs: iord=1, mem_read=1
  - mem_ready=1 -> WB_MEM
- MEM_WR:
  - outputs: iord=1, mem_write=1
  - mem_ready=1 -> retire
- WB_MEM: reg_write=1, mem_to_reg=1 -> retire
- EXEC_R: alu_src_a=1, alu_src_b=00, aluop=10 -> WB_R
- WB_R: reg_write=1, mem_to_reg=0 -> retire
- BRANCH:
  - outputs: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=1, pc_write=zero
  - -> retire
- Retire transition:
  - retire=1 for that cycle; instr_count increments, wrapping from 2^32-1 to 0
  - next state = FETCH if run=1, else IDLE
- run is sampled only in IDLE and at retire. Deasserting run mid-instruction never aborts the instruction.
- Timeout counter (wait_cnt):
  - cleared on entry to FETCH, MEM_RD or MEM_WR, and on any cycle with mem_ready=1
  - increments on each cycle spent in one of those states with mem_ready=0
  - if mem_ready=0 and wait_cnt==MEM_TIMEOUT-1 -> FAULT, fault_code=10; i.e. the MEM_TIMEOUT-th consecutive not-ready cycle faults
  - mem_ready=1 on that same cycle takes priority: no fault
- FAULT: all controls 0, fault=1, fault_code held. Exit only by reset.
- Latency with mem_ready=1 always: BEQ 3 cycles, R-type 4, SW 4, LW 5 (FETCH through retire).

Test Plan:
- R-type, reset release, run=1, mem_ready=1, opcode=0110011:
  - states FETCH, DECODE, EXEC_R, WB_R
  - aluop=10 in cycle 3; reg_write=1 and retire=1 in cycle 4; instr_count=1; then FETCH
- LW, mem_ready low for 3 cycles in MEM_RD:
  - mem_read=1 and iord=1 for 4 cycles
  - then one cycle of reg_write=1 with mem_to_reg=1
  - total 8 cycles, retire once
- BEQ:
  - zero=1 -> BRANCH with aluop=01, pc_src=1, pc_write=1
  - zero=0 -> pc_write=0
  - both cases: retire in cycle 3
- Illegal opcode 0010011:
  - after DECODE, fault=1, fault_code=01, busy=0, all controls 0 for 20+ cycles
  - rst_n pulse low -> IDLE, fault=0
- Timeout, MEM_TIMEOUT=16, mem_ready=0 in FETCH:
  - after 16 FETCH cycles -> FAULT, fault_code=10
  - repeat with mem_ready=1 on the 16th cycle -> DECODE, no fault
- Stop and reset:
  - run dropped during MEM_WR -> SW completes, retire=1, IDLE, busy=0
  - rst_n low mid-MEM_RD -> immediately IDLE, all outputs 0, instr_count=0
